// File: rtl/watch_set_ctrl.sv
// watch_set_ctrl: hour/minute time-setting FSM with display mux and field blink for a BCD watch
module watch_set_ctrl #(
    parameter int TIMEOUT_S = 10,
    parameter int TO_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [1:0] cur_hour_10,
    input  logic [3:0] cur_hour_1,
    input  logic [2:0] cur_min_10,
    input  logic [3:0] cur_min_1,
    output logic       load,
    output logic [1:0] ld_hour_10,
    output logic [3:0] ld_hour_1,
    output logic [2:0] ld_min_10,
    output logic [3:0] ld_min_1,
    output logic [1:0] mode,
    output logic [1:0] disp_hour_10,
    output logic [3:0] disp_hour_1,
    output logic [2:0] disp_min_10,
    output logic [3:0] disp_min_1,
    output logic       blank_hour,
    output logic       blank_min
);
    localparam logic [1:0] RUN = 2'd0, SET_HOUR = 2'd1, SET_MIN = 2'd2;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_S - 1);
    logic mode_q, inc_q, blink, press_mode, press_inc, tick_to;
    logic [TO_W-1:0] to_cnt;
    assign press_mode = btn_mode & ~mode_q;
    assign press_inc = btn_inc & ~inc_q & ~press_mode;
    assign tick_to = tick_1hz && to_cnt == TO_LAST;
    assign disp_hour_10 = mode == RUN ? cur_hour_10 : ld_hour_10;
    assign disp_hour_1 = mode == RUN ? cur_hour_1 : ld_hour_1;
    assign disp_min_10 = mode == RUN ? cur_min_10 : ld_min_10;
    assign disp_min_1 = mode == RUN ? cur_min_1 : ld_min_1;
    assign blank_hour = blink & (mode == SET_HOUR);
    assign blank_min = blink & (mode == SET_MIN);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode <= RUN;
            load <= 1'b0;
            ld_hour_10 <= '0;
            ld_hour_1 <= '0;
            ld_min_10 <= '0;
            ld_min_1 <= '0;
            blink <= 1'b0;
            to_cnt <= '0;
            mode_q <= 1'b1;
            inc_q <= 1'b1;
        end else begin
            mode_q <= btn_mode;
            inc_q <= btn_inc;
            load <= 1'b0;
            if (mode == RUN) begin
                if (press_mode) begin
                    ld_hour_10 <= cur_hour_10;
                    ld_hour_1 <= cur_hour_1;
                    ld_min_10 <= cur_min_10;
                    ld_min_1 <= cur_min_1;
                    mode <= SET_HOUR;
                    blink <= 1'b0;
                    to_cnt <= '0;
                end
            end else if (press_mode) begin
                mode <= mode == SET_HOUR ? SET_MIN : RUN;
                load <= mode == SET_MIN;
                blink <= 1'b0;
                to_cnt <= '0;
            end else if (press_inc) begin
                if (mode == SET_HOUR) begin
                    if (ld_hour_10 == 2'd2 && ld_hour_1 == 4'd3) begin
                        ld_hour_10 <= 2'd0;
                        ld_hour_1 <= 4'd0;
                    end else if (ld_hour_1 == 4'd9) begin
                        ld_hour_10 <= ld_hour_10 + 2'd1;
                        ld_hour_1 <= 4'd0;
                    end else begin
                        ld_hour_1 <= ld_hour_1 + 4'd1;
                    end
                end else begin
                    ld_min_1 <= ld_min_1 == 4'd9 ? 4'd0 : ld_min_1 + 4'd1;
                    if (ld_min_1 == 4'd9)
                        ld_min_10 <= ld_min_10 == 3'd5 ? 3'd0 : ld_min_10 + 3'd1;
                end
                to_cnt <= '0;
                blink <= blink ^ tick_1hz;
            end else if (tick_to) begin
                mode <= RUN;
                blink <= 1'b0;
                to_cnt <= '0;
            end else if (tick_1hz) begin
                to_cnt <= to_cnt + 1'b1;
                blink <= ~blink;
            end
        end
    end
endmodule

// File: tb/tb_watch_set_ctrl.sv
// tb_watch_set_ctrl: directed and random stimulus, expected outputs queued from an
// integer-arithmetic time-setting model and checked every cycle by a separate monitor.
module tb_watch_set_ctrl;
    localparam int TIMEOUT_S = 10;
    logic clk = 1'b0, rst, tick_1hz, btn_mode, btn_inc, load, blank_hour, blank_min;
    logic [1:0] cur_hour_10, ld_hour_10, disp_hour_10, mode;
    logic [3:0] cur_hour_1, ld_hour_1, disp_hour_1, cur_min_1, ld_min_1, disp_min_1;
    logic [2:0] cur_min_10, ld_min_10, disp_min_10;
    logic [30:0] act;
    logic [30:0] exp_q[$];
    int n_chk = 0, n_pass = 0;
    int cur_h, cur_m, m_md, m_eh, m_em, m_to;
    bit m_bl, m_pbm, m_pbi;

    watch_set_ctrl #(.TIMEOUT_S(TIMEOUT_S), .TO_W(8)) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .cur_hour_10(cur_hour_10), .cur_hour_1(cur_hour_1), .cur_min_10(cur_min_10),
        .cur_min_1(cur_min_1), .load(load), .ld_hour_10(ld_hour_10), .ld_hour_1(ld_hour_1),
        .ld_min_10(ld_min_10), .ld_min_1(ld_min_1), .mode(mode), .disp_hour_10(disp_hour_10),
        .disp_hour_1(disp_hour_1), .disp_min_10(disp_min_10), .disp_min_1(disp_min_1),
        .blank_hour(blank_hour), .blank_min(blank_min)
    );

    always #5 clk = ~clk;
    assign act = {mode, load, ld_hour_10, ld_hour_1, ld_min_10, ld_min_1,
                  disp_hour_10, disp_hour_1, disp_min_10, disp_min_1, blank_hour, blank_min};

    function automatic logic [30:0] pack(int md, bit ld, int eh, int em, int dh, int dm, bit bh, bit bm);
        return {2'(md), ld, 2'(eh / 10), 4'(eh % 10), 3'(em / 10), 4'(em % 10),
                2'(dh / 10), 4'(dh % 10), 3'(dm / 10), 4'(dm % 10), bh, bm};
    endfunction

    task automatic chk(input string nm, input logic [30:0] a, input logic [30:0] e);
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, a, e, $time);
    endtask

    task automatic drive_cur();
        cur_hour_10 = 2'(cur_h / 10);
        cur_hour_1 = 4'(cur_h % 10);
        cur_min_10 = 3'(cur_m / 10);
        cur_min_1 = 4'(cur_m % 10);
    endtask

    // Called at a falling edge; drives one cycle of inputs and queues the post-edge outputs.
    task automatic step(input bit bm, input bit bi, input bit tk);
        bit pm, pi, ld;
        btn_mode = bm;
        btn_inc = bi;
        tick_1hz = tk;
        drive_cur();
        pm = bm && !m_pbm;
        pi = bi && !m_pbi && !pm;
        m_pbm = bm;
        m_pbi = bi;
        ld = 1'b0;
        if (m_md == 0) begin
            if (pm) begin
                m_eh = cur_h;
                m_em = cur_m;
                m_md = 1;
                m_bl = 1'b0;
                m_to = 0;
            end
        end else if (pm) begin
            ld = m_md == 2;
            m_md = m_md == 1 ? 2 : 0;
            m_bl = 1'b0;
            m_to = 0;
        end else begin
            if (pi) begin
                if (m_md == 1) m_eh = (m_eh + 1) % 24;
                else m_em = (m_em + 1) % 60;
                m_to = 0;
            end else if (tk) m_to++;
            if (tk) m_bl = !m_bl;
            if (m_to == TIMEOUT_S) begin
                m_md = 0;
                m_bl = 1'b0;
                m_to = 0;
            end
        end
        exp_q.push_back(pack(m_md, ld, m_eh, m_em, m_md == 0 ? cur_h : m_eh,
                             m_md == 0 ? cur_m : m_em, m_bl && m_md == 1, m_bl && m_md == 2));
        @(negedge clk);
    endtask

    task automatic press(input bit bm, input bit bi);
        step(bm, bi, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input bit hold_mode);
        btn_mode = hold_mode;
        btn_inc = 1'b0;
        tick_1hz = 1'b0;
        drive_cur();
        rst = 1'b0;
        #1;
        chk("async_reset", act, pack(0, 1'b0, 0, 0, cur_h, cur_m, 1'b0, 1'b0));
        @(negedge clk);
        rst = 1'b1;
        m_md = 0;
        m_eh = 0;
        m_em = 0;
        m_to = 0;
        m_bl = 1'b0;
        m_pbm = 1'b1;
        m_pbi = 1'b1;
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) chk("cycle", act, exp_q.pop_front());
    end

    initial begin
        rst = 1'b1;
        btn_mode = 1'b0;
        btn_inc = 1'b0;
        tick_1hz = 1'b0;
        cur_h = 13;
        cur_m = 45;
        drive_cur();
        @(negedge clk);
        do_reset(1'b1);
        repeat (4) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        // 13:45 edited to 16:47
        press(1'b1, 1'b0);
        repeat (3) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        repeat (2) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        cur_h = 22;
        cur_m = 58;
        press(1'b1, 1'b0);
        repeat (2) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        repeat (2) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        // idle timeout from SET_HOUR
        press(1'b1, 1'b0);
        repeat (TIMEOUT_S) begin
            step(1'b0, 1'b0, 1'b1);
            step(1'b0, 1'b0, 1'b0);
        end
        repeat (3) step(1'b0, 1'b0, 1'b0);
        // INC on the timeout-reaching tick keeps the edit alive
        press(1'b1, 1'b0);
        repeat (TIMEOUT_S - 1) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        repeat (TIMEOUT_S) step(1'b0, 1'b0, 1'b1);
        // MODE and INC together in SET_MIN
        cur_h = 10;
        cur_m = 20;
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        // reset in the middle of SET_MIN
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        do_reset(1'b0);
        repeat (2) step(1'b0, 1'b0, 1'b0);
        // blink in SET_HOUR while live time differs from the edit
        cur_h = 7;
        cur_m = 5;
        press(1'b1, 1'b0);
        cur_h = 19;
        cur_m = 33;
        repeat (3) step(1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b0);
        for (int i = 0; i < 4000; i++) begin
            int rate;
            rate = i < 2000 ? 3 : 40;
            if ($urandom_range(0, 15) == 0) begin
                cur_h = $urandom_range(0, 23);
                cur_m = $urandom_range(0, 59);
            end
            if ($urandom_range(0, 599) == 0) do_reset(1'($urandom_range(0, 1)));
            else step($urandom_range(0, rate) == 0, $urandom_range(0, rate / 2) == 0,
                      $urandom_range(0, 4) == 0);
        end
        step(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("drain", 31'(exp_q.size()), 31'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/watch_set_ctrl.md
Name: watch_set_ctrl

Overview:
- Time-setting controller for the 24-hour BCD watch counter chain.
- Takes pre-debounced MODE and INC buttons and walks the user through editing hours, then minutes.
- On commit, issues a one-cycle load strobe with the edited hour/minute BCD digits and a seconds clear. It also muxes the display digits and generates field blinking.
- The watch keeps counting while the user edits; the edited time replaces it only on commit.

Parameters:
- TIMEOUT_S, 10, number of tick_1hz pulses with no accepted press before an edit aborts; range 2..255.
- TO_W, 8, width of the timeout counter.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- tick_1hz  input  1  one-clk-wide pulse, once per second
- btn_mode  input  1  debounced MODE button level, active-high
- btn_inc  input  1  debounced INC button level, active-high
- cur_hour_10  input  2  live watch hour tens (0..2)
- cur_hour_1  input  4  live watch hour units (0..9)
- cur_min_10  input  3  live watch minute tens (0..5)
- cur_min_1  input  4  live watch minute units (0..9)
- load  output  1  one-cycle strobe: watch loads ld_* digits and clears seconds to 00
- ld_hour_10  output  2  edited hour tens
- ld_hour_1  output  4  edited hour units
- ld_min_10  output  3  edited minute tens
- ld_min_1  output  4  edited minute units
- mode  output  2  current state: 0 RUN, 1 SET_HOUR, 2 SET_MIN
- disp_hour_10, disp_hour_1, disp_min_10, disp_min_1  output  2/4/3/4  digits to display
- blank_hour  output  1  blank the hour digits (blink phase)
- blank_min  output  1  blank the minute digits (blink phase)

Behaviour:
- Reset (rst=0, asynchronous):
  - mode=RUN, load=0, all edit/ld_* digits=0, blink=0, timeout count=0.
  - Button history registers are set to 1, so a button held through reset release is not a press.
- Press detection:
  - press_x = btn_x & ~btn_x_q, where btn_x_q is the button level registered every clk.
  - A press is acted on at the first rising edge where the button is sampled high. There is no auto-repeat.
- Simultaneous presses: MODE and INC in the same cycle means MODE is acted on and INC is dropped.
- RUN state:
  - On MODE press: capture cur_* into the edit registers, mode goes to SET_HOUR, blink=0, timeout=0.
  - INC press is ignored.
- SET_HOUR state:
  - INC press increments the edit hour in BCD, 00..23:
    - h10=2 and h1=3 gives 00;
    - else h1=9 gives h10+1, h1=0;
    - else h1+1.
  - MODE press: mode goes to SET_MIN, blink=0, timeout=0.
- SET_MIN state:
  - INC press increments the edit minute in BCD, 00..59: m1=9 gives m1=0 and m10=(m10==5 ? 0 : m10+1); else m1+1.
  - MODE press: mode goes to RUN and load=1 for exactly the next cycle.
- ld_* outputs: always equal the edit registers and are stable during load.
- Timeout:
  - In SET_* states the counter increments on each tick_1hz and clears on any accepted press.
  - When the count reaches TIMEOUT_S, mode goes to RUN with no load; edits are discarded.
  - A press in the same cycle as the timeout-reaching tick takes priority; the count clears.
- Blink:
  - In SET_* states, blink toggles on each tick_1hz; in RUN it is held at 0.
  - blank_hour = blink & (mode==SET_HOUR); blank_min = blink & (mode==SET_MIN).
- Display mux (combinational): disp_* = edit digits in SET_* states, cur_* digits in RUN.
- The controller never modifies the live watch except through load.
- Reset mid-edit returns to RUN; no load is issued.

Test Plan:
- Reset, then release with btn_mode held high -> no state change; mode=0, load=0, all ld_*=0.
- cur=13:45, press MODE, INC×3, MODE, INC×2, MODE -> load pulses exactly 1 cycle with ld=16:47, mode=0.
- Edit hour from 22, INC×2 -> 23 then 00. Edit minute from 58, INC×2 -> 59 then 00.
- Enter SET_HOUR, apply no presses for 10 tick_1hz pulses -> mode returns to 0 on the 10th tick, load never asserts.
- In SET_MIN, btn_mode and btn_inc rise in the same cycle -> load=1, minute unchanged (INC dropped). Assert rst during SET_MIN -> mode=0, no load.
- In SET_HOUR, apply 3 tick_1hz pulses -> blank_hour sequence 1,0,1; blank_min stays 0; disp_* show edit digits, not cur_*.
